// File: rtl/excess3_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// excess3_to_bcd_seq
//
// Purpose:
//   Sequential excess-3 to packed-BCD decoder. It undoes the team's
//   combinational BCD-to-excess-3 encoder. A whole n-digit excess-3 word is
//   taken through a valid/ready handshake. The block then decodes one digit
//   per clock, LSB digit first, using a single 4-bit subtractor. The BCD word
//   and per-digit error flags are offered through a second valid/ready
//   handshake.
//
// Parameters:
//   n          number of 4-bit digits per word (n >= 1)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   an excess-3 word is offered
//   in_ready   block can accept a word (only in IDLE)
//   excess     excess-3 word, digit i at excess[4*i +: 4]
//   out_valid  decoded result is available (only in DONE)
//   out_ready  consumer takes the result
//   bcd        decoded BCD word, digit i at bcd[4*i +: 4]
//   err_mask   bit i set when input digit i was not a legal excess-3 code
//   err        OR of err_mask, meaningful while out_valid is high
// ---------------------------------------------------------------------------
module excess3_to_bcd_seq #(
    parameter int n = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*n-1:0] excess,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*n-1:0] bcd,
    output logic [n-1:0]   err_mask,
    output logic           err
);

    // The counter must always be at least one bit wide, even when n is 1.
    localparam int cw = (n > 1) ? $clog2(n) : 1;
    localparam logic [cw-1:0] last_cnt = cw'(n - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t          state;
    logic [4*n-1:0]  hold;
    logic [cw-1:0]   cnt;
    logic [3:0]      digit;
    logic [3:0]      digit_bcd;
    logic            digit_err;

    // Pick the digit that the counter points at out of the holding register.
    // Decode it with the one shared subtractor. Legal excess-3 codes are 3
    // through 12. Any other code decodes to zero and raises the error flag.
    // This matches the encoder's "emit 0 for non-BCD" behaviour. Inside the
    // legal range the subtraction cannot borrow.
    always_comb begin
        digit     = hold[{cnt, 2'b00} +: 4];
        digit_bcd = 4'd0;
        digit_err = 1'b1;
        if ((digit >= 4'd3) && (digit <= 4'd12)) begin
            digit_bcd = digit - 4'd3;
            digit_err = 1'b0;
        end
    end

    // Control FSM and datapath registers live together here, so the
    // handshake outputs are registered. The input word is latched on accept,
    // which leaves the upstream free to change excess during conversion. The
    // counter stops at the last digit instead of incrementing. As a result it
    // never wraps, whatever n is. The outputs keep their last result through
    // IDLE until the next word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            hold      <= '0;
            bcd       <= '0;
            err_mask  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold     <= excess;
                        bcd      <= '0;
                        err_mask <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd[{cnt, 2'b00} +: 4] <= digit_bcd;
                    err_mask[cnt]          <= digit_err;
                    if (cnt == last_cnt) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // The summary error bit is a plain OR, so it follows err_mask with no
    // extra cycle of delay.
    assign err = |err_mask;

endmodule

// File: doc/excess3_to_bcd_seq.md
Name: excess3_to_bcd_seq

Overview:
- Sequential excess-3 to packed-BCD decoder; the inverse of the team's combinational BCD-to-excess-3 encoder.
- Accepts an N-digit excess-3 word through a valid/ready handshake and converts one digit per clock, LSB digit first.
- Presents the BCD result with per-digit error flags through a second valid/ready handshake.
- Sits between the excess-3 encode path and downstream BCD consumers; the serial datapath keeps to a single 4-bit subtractor for any N.

Parameters:
- n, 1, number of 4-bit digits per word (n >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  excess word offered.
- in_ready  output  1  block can accept a word.
- excess  input  4*n  excess-3 word; digit i is excess[4*i +: 4].
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- bcd  output  4*n  decoded BCD word; digit i is bcd[4*i +: 4].
- err_mask  output  n  bit i set when input digit i was invalid.
- err  output  1  OR of err_mask; valid with out_valid.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), sampled on the clk rising edge.
- Reset: state IDLE, in_ready=1, out_valid=0, bcd=0, err_mask=0, err=0, digit counter=0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid=1, the edge captures excess into a holding register, clears bcd and err_mask, sets the counter to 0, and moves to CONV.
  - CONV: in_ready=0, out_valid=0. Each edge decodes digit d=hold[4*cnt +: 4] and increments cnt. On the edge that decodes digit n-1, move to DONE.
  - DONE: out_valid=1, in_ready=0. Outputs are stable. When out_ready=1, the edge moves to IDLE. Outputs keep their values in IDLE until the next accept.
- Digit rule:
  - 4'd3 <= d <= 4'd12: bcd digit = d - 4'd3 (4-bit result, no borrow possible), err_mask[cnt]=0.
  - d in {0,1,2,13,14,15}: bcd digit = 4'b0000, err_mask[cnt]=1. This mirrors the encoder, which emits 0 for non-BCD input.
- err is combinational OR of err_mask, gated by nothing; it is meaningful only while out_valid=1.
- Latency:
  - Accept edge E0; digit i is written at edge E(i+1); out_valid rises after edge En. For n=3 that is 3 cycles after accept.
  - Minimum spacing between accepts is n+2 cycles (accept, n converts, output handshake).
- The counter width is max(1, $clog2(n)). No wrap occurs, because the transition to DONE happens at cnt=n-1.
- in_valid is ignored outside IDLE. The excess input may change freely after the accept edge, since the holding register is used.
- out_ready is ignored outside DONE. out_ready held at 1 continuously gives back-to-back operation at n+2 cycles/word.
- rst asserted in any state, including mid-CONV or in DONE with out_valid=1, returns to the reset values on that edge. The partial result is discarded and no out_valid pulse is produced.
- With n=1: CONV lasts exactly one cycle.

Test Plan:
- n=3, rst 2 cycles, then check idle outputs -> in_ready=1, out_valid=0, bcd=12'h000, err_mask=3'b000.
- n=3, excess=12'h4C3, in_valid 1 cycle, out_ready=1 -> out_valid exactly 3 cycles after accept edge for 1 cycle; bcd=12'h190, err_mask=3'b000, err=0; in_ready=1 the following cycle.
- n=3, excess=12'hF9D -> bcd=12'h060, err_mask=3'b101, err=1.
- n=3, excess=12'hC3C with out_ready=0 for 5 cycles after out_valid -> bcd=12'h909 held stable, out_valid stays 1 and in_ready stays 0. A new in_valid during the stall is not accepted. Releasing out_ready returns to IDLE next edge.
- n=3, accept 12'h4C3, assert rst on the second CONV cycle -> next cycle in_ready=1, out_valid=0, bcd=0, err_mask=0. No out_valid is ever seen for that word.
- n=1, sweep every value 0..15 with out_ready=1 -> for 3..12 bcd=value-3 and err=0; others give bcd=0 and err=1. Each result appears 1 cycle after accept.
